norm_channel_sequencer: RTL and testbench

//  Front-end controller for the normalization/activation FP pipeline. Streams one layer's pixels
//  (channel-major) into the pipeline, applying each output channel's per-channel const_1/const_2

---
 rtl/norm_channel_sequencer_pkg.sv | 12 +
 rtl/norm_result_fifo.sv | 51 +++++
 rtl/norm_channel_sequencer.sv | 154 +++++++++++++++
 tb/tb_norm_channel_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/norm_channel_sequencer_pkg.sv
// Shared widths and sequencer state encoding for the normalization front-end.
package norm_channel_sequencer_pkg;
  localparam int BRAM_DATA_WIDTH           = 16;
  localparam int NORMALIZATION_CONST_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;
endpackage

// File: rtl/norm_result_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; pop_data valid whenever !empty.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module norm_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/norm_channel_sequencer.sv
// Streams a channel-major layer into the FP pipeline with per-channel constants (1-cycle issue latency).
// Issue is credit-limited so in-flight plus buffered results never exceed the result FIFO depth.
module norm_channel_sequencer
  import norm_channel_sequencer_pkg::*;
#(
  parameter int NUM_CHANNELS   = 64,
  parameter int CH_ADDR_WIDTH  = 6,
  parameter int PIX_CNT_WIDTH  = 16,
  parameter int OUT_FIFO_DEPTH = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cfg_wr_en,
  input  logic [CH_ADDR_WIDTH-1:0]             cfg_wr_addr,
  input  logic [NORMALIZATION_CONST_WIDTH-1:0] cfg_wr_const_1,
  input  logic [NORMALIZATION_CONST_WIDTH-1:0] cfg_wr_const_2,
  input  logic                                 start,
  input  logic [CH_ADDR_WIDTH:0]               cfg_num_channels,
  input  logic [PIX_CNT_WIDTH-1:0]             cfg_pix_per_channel,
  input  logic                                 cfg_activation_en,
  input  logic [BRAM_DATA_WIDTH-1:0]           pix_in_data,
  input  logic                                 pix_in_valid,
  output logic                                 pix_in_ready,
  output logic [BRAM_DATA_WIDTH-1:0]           norm_pixel_data,
  output logic                                 norm_pixel_valid,
  output logic [NORMALIZATION_CONST_WIDTH-1:0] norm_const_1,
  output logic [NORMALIZATION_CONST_WIDTH-1:0] norm_const_2,
  output logic                                 norm_activation_en,
  input  logic [BRAM_DATA_WIDTH-1:0]           norm_result_data,
  input  logic                                 norm_result_valid,
  output logic [BRAM_DATA_WIDTH-1:0]           out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err_overflow
);
  localparam int CW = $clog2(OUT_FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = OUT_FIFO_DEPTH[CW:0];

  seq_state_t state, state_nxt;

  logic [NORMALIZATION_CONST_WIDTH-1:0] c1_tab [NUM_CHANNELS];
  logic [NORMALIZATION_CONST_WIDTH-1:0] c2_tab [NUM_CHANNELS];

  logic [CH_ADDR_WIDTH:0]   nch_r;
  logic [CH_ADDR_WIDTH:0]   ch_cnt;
  logic [PIX_CNT_WIDTH-1:0] ppc_r;
  logic [PIX_CNT_WIDTH-1:0] pix_cnt;
  logic                     act_r;
  logic [CW-1:0]            inflight;
  logic [CW-1:0]            fifo_count;
  logic [CW:0]              credit_used;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     issue;
  logic                     receive;
  logic                     pop;
  logic                     pix_wrap;
  logic                     last_pix;

  assign credit_used  = {1'b0, inflight} + {1'b0, fifo_count};
  assign pix_in_ready = (state == RUN) && (credit_used < CREDITS);
  assign issue        = pix_in_valid && pix_in_ready;
  assign pix_wrap     = (pix_cnt == ppc_r - 1'b1);
  assign last_pix     = pix_wrap && (ch_cnt == nch_r - 1'b1);
  // Results with nothing outstanding are leftovers from before a reset.
  assign receive      = norm_result_valid && (inflight != '0);
  assign out_valid    = !fifo_empty;
  assign pop          = out_valid && out_ready;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = ((cfg_num_channels == '0) || (cfg_pix_per_channel == '0)) ? DONE : RUN;
      RUN:   if (issue && last_pix) state_nxt = DRAIN;
      DRAIN: if ((inflight == '0) && fifo_empty) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      nch_r              <= '0;
      ppc_r              <= '0;
      act_r              <= 1'b0;
      ch_cnt             <= '0;
      pix_cnt            <= '0;
      inflight           <= '0;
      norm_pixel_valid   <= 1'b0;
      norm_pixel_data    <= '0;
      norm_const_1       <= '0;
      norm_const_2       <= '0;
      norm_activation_en <= 1'b0;
      err_overflow       <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        nch_r   <= cfg_num_channels;
        ppc_r   <= cfg_pix_per_channel;
        act_r   <= cfg_activation_en;
        ch_cnt  <= '0;
        pix_cnt <= '0;
      end
      if (issue) begin
        if (pix_wrap) begin
          pix_cnt <= '0;
          ch_cnt  <= ch_cnt + 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
      case ({issue, receive})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      norm_pixel_valid   <= issue;
      norm_activation_en <= act_r;
      if (issue) begin
        norm_pixel_data <= pix_in_data;
        norm_const_1    <= c1_tab[ch_cnt[CH_ADDR_WIDTH-1:0]];
        norm_const_2    <= c2_tab[ch_cnt[CH_ADDR_WIDTH-1:0]];
      end
      if (receive && fifo_full && !pop) err_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_wr_en && (state == IDLE)) begin
      c1_tab[cfg_wr_addr] <= cfg_wr_const_1;
      c2_tab[cfg_wr_addr] <= cfg_wr_const_2;
    end
  end

  norm_result_fifo #(
    .WIDTH (BRAM_DATA_WIDTH),
    .DEPTH (OUT_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (receive),
    .push_data (norm_result_data),
    .pop       (pop),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_norm_channel_sequencer.sv
// Bench: FP pipeline modelled as a 12-cycle y = c1*x + c2 delay line; results scoreboarded in order.
module tb_norm_channel_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_wr_en = 1'b0;
  logic [5:0]  cfg_wr_addr = '0;
  logic [15:0] cfg_wr_const_1 = '0;
  logic [15:0] cfg_wr_const_2 = '0;
  logic        start = 1'b0;
  logic [6:0]  cfg_num_channels = '0;
  logic [15:0] cfg_pix_per_channel = '0;
  logic        cfg_activation_en = 1'b0;
  logic [15:0] pix_in_data = '0;
  logic        pix_in_valid = 1'b0;
  logic        pix_in_ready;
  logic [15:0] norm_pixel_data;
  logic        norm_pixel_valid;
  logic [15:0] norm_const_1, norm_const_2;
  logic        norm_activation_en;
  logic [15:0] norm_result_data;
  logic        norm_result_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy, done, err_overflow;

  int total = 0;
  int bad = 0;
  logic [15:0] tb_c1 [64];
  logic [15:0] tb_c2 [64];
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];

  always #5 clk = ~clk;

  norm_channel_sequencer dut (
    .clk(clk), .reset(reset),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_const_1(cfg_wr_const_1), .cfg_wr_const_2(cfg_wr_const_2),
    .start(start), .cfg_num_channels(cfg_num_channels),
    .cfg_pix_per_channel(cfg_pix_per_channel), .cfg_activation_en(cfg_activation_en),
    .pix_in_data(pix_in_data), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
    .norm_pixel_data(norm_pixel_data), .norm_pixel_valid(norm_pixel_valid),
    .norm_const_1(norm_const_1), .norm_const_2(norm_const_2),
    .norm_activation_en(norm_activation_en),
    .norm_result_data(norm_result_data), .norm_result_valid(norm_result_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err_overflow(err_overflow)
  );

  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) begin v = real'(h[9:0]) / 1024.0; e = -14; end
    else begin v = 1.0 + real'(h[9:0]) / 1024.0; e = e - 15; end
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real v);
    real  a;
    int   e;
    int   m;
    logic s;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    if (m == 1024) begin m = 0; e++; end
    return {s, e[4:0], m[9:0]};
  endfunction

  // Pipeline model: not reset, so stale results survive a sequencer reset.
  logic        pv [12] = '{default: 1'b0};
  logic [15:0] py [12] = '{default: 16'h0};
  always @(posedge clk) begin
    pv[0] <= norm_pixel_valid;
    py[0] <= r2h(h2r(norm_const_1) * h2r(norm_pixel_data) + h2r(norm_const_2));
    for (int i = 1; i < 12; i++) begin
      pv[i] <= pv[i-1];
      py[i] <= py[i-1];
    end
  end
  assign norm_result_valid = pv[11];
  assign norm_result_data  = py[11];

  task automatic write_const(input int ch, input logic [15:0] c1, input logic [15:0] c2);
    @(negedge clk);
    cfg_wr_en = 1'b1; cfg_wr_addr = ch[5:0]; cfg_wr_const_1 = c1; cfg_wr_const_2 = c2;
    tb_c1[ch] = c1; tb_c2[ch] = c2;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  // Runs one layer; disturb >= 2 injects an ignored table write and a second start mid-layer.
  task automatic stream_layer(input int nch, input int ppc, input bit act, input int rdy_pct,
                              input int stall, input bit seq_pix, input int disturb,
                              output int acc_stall, output bit rdy_in_stall, output int max_out,
                              output int done_cnt, output bit ok);
    int sent, got, npix, tail, ch;
    logic [15:0] cur, e;
    npix = nch * ppc; sent = 0; got = 0; tail = -1;
    max_out = 0; done_cnt = 0; acc_stall = 0; rdy_in_stall = 1'b0;
    exp_q.delete(); obs_q.delete();
    cur = seq_pix ? r2h(1.0) : r2h(real'($urandom_range(63)));
    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(negedge clk);
      start               = (cyc == 0) || (cyc == disturb);
      cfg_num_channels    = (cyc == 0) ? nch[6:0] : 7'd1;
      cfg_pix_per_channel = (cyc == 0) ? ppc[15:0] : 16'd3;
      cfg_activation_en   = (cyc == 0) ? act : !act;
      cfg_wr_en           = (cyc == disturb);
      cfg_wr_addr         = 6'd0;
      cfg_wr_const_1      = 16'h5555;
      cfg_wr_const_2      = 16'h5555;
      pix_in_valid        = (sent < npix);
      pix_in_data         = cur;
      out_ready           = (cyc < stall) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      #1;
      if (done) done_cnt++;
      if (cyc == stall) begin acc_stall = sent; rdy_in_stall = pix_in_ready; end
      if (norm_pixel_valid) begin
        total++;
        if (norm_activation_en !== act) begin
          bad++;
          $display("FAIL act_en: got %b want %b", norm_activation_en, act);
        end
      end
      if (pix_in_valid && pix_in_ready) begin
        ch = sent / ppc;
        e = r2h(h2r(tb_c1[ch]) * h2r(cur) + h2r(tb_c2[ch]));
        exp_q.push_back(e);
        sent++;
        cur = seq_pix ? r2h(real'(sent + 1)) : r2h(real'($urandom_range(63)));
      end
      if (out_valid && out_ready) begin
        obs_q.push_back(out_data);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL result_order: unexpected out_data=%h with none outstanding", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            bad++;
            $display("FAIL result_data[%0d]: got %h want %h", got, out_data, e);
          end
        end
        got++;
      end
      if (sent - got > max_out) max_out = sent - got;
      if (tail < 0 && got == npix && done_cnt > 0) tail = 4;
      if (tail == 0) break;
      if (tail > 0) tail--;
    end
    ok = (got == npix) && (tail == 0);
    start = 1'b0; cfg_wr_en = 1'b0; pix_in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({pix_in_ready, out_valid, norm_pixel_valid, done, err_overflow, busy, norm_activation_en} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000000",
               {pix_in_ready, out_valid, norm_pixel_valid, done, err_overflow, busy, norm_activation_en});
    end
    total++;
    if ({norm_pixel_data, norm_const_1, norm_const_2} !== 48'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {norm_pixel_data, norm_const_1, norm_const_2});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int as, mo, dc; bit ri, ok;
    logic [15:0] lit [6];
    lit = '{16'h4200, 16'h4500, 16'h4700, 16'h4000, 16'h4100, 16'h4200};
    write_const(0, 16'h4000, 16'h3C00);
    write_const(1, 16'h3800, 16'h0000);
    stream_layer(2, 3, 1'b0, 100, 0, 1'b1, -1, as, ri, mo, dc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_complete: layer did not finish"); end
    total++;
    if (dc != 1) begin bad++; $display("FAIL basic_done: got %0d pulses want 1", dc); end
    total++;
    if (obs_q.size() != 6) begin bad++; $display("FAIL basic_count: got %0d want 6", obs_q.size()); end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== lit[i]) begin
        bad++;
        $display("FAIL basic_value[%0d]: got %h want %h", i, obs_q[i], lit[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int as, mo, dc; bit ri, ok;
    stream_layer(1, 40, 1'b0, 100, 60, 1'b0, -1, as, ri, mo, dc, ok);
    total++;
    if (as != 16) begin bad++; $display("FAIL bp_accepted: got %0d want 16", as); end
    total++;
    if (ri !== 1'b0) begin bad++; $display("FAIL bp_ready: got %b want 0", ri); end
    total++;
    if (err_overflow !== 1'b0) begin bad++; $display("FAIL bp_overflow: got %b want 0", err_overflow); end
    total++;
    if (!ok || dc != 1) begin bad++; $display("FAIL bp_finish: ok=%b done=%0d want ok=1 done=1", ok, dc); end
  endtask

  task automatic test_random_ready();
    int as, mo, dc; bit ri, ok;
    logic [15:0] c1s [4];
    logic [15:0] c2s [4];
    c1s = '{16'h3C00, 16'h4000, 16'h3800, 16'h3400};
    c2s = '{16'h0000, 16'h3C00, 16'hBC00, 16'h4200};
    for (int ch = 0; ch < 4; ch++)
      write_const(ch, c1s[$urandom_range(3)], c2s[$urandom_range(3)]);
    stream_layer(4, 100, 1'b0, 30, 0, 1'b0, -1, as, ri, mo, dc, ok);
    total++;
    if (!ok || obs_q.size() != 400) begin
      bad++; $display("FAIL rnd_complete: ok=%b results=%0d want 400", ok, obs_q.size());
    end
    total++;
    if (mo > 16) begin bad++; $display("FAIL rnd_credits: outstanding %0d want <=16", mo); end
    total++;
    if (dc != 1) begin bad++; $display("FAIL rnd_done: got %0d want 1", dc); end
    total++;
    if (err_overflow !== 1'b0) begin bad++; $display("FAIL rnd_overflow: got %b want 0", err_overflow); end
  endtask

  task automatic test_empty_layer();
    int first, dcnt; bit rdy_seen;
    int ncfg [2];
    int pcfg [2];
    ncfg = '{2, 0};
    pcfg = '{0, 5};
    for (int k = 0; k < 2; k++) begin
      first = -1; dcnt = 0; rdy_seen = 1'b0;
      @(negedge clk);
      start = 1'b1; cfg_num_channels = ncfg[k][6:0]; cfg_pix_per_channel = pcfg[k][15:0];
      pix_in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        start = 1'b0;
        #1;
        if (done) begin dcnt++; if (first < 0) first = c + 1; end
        if (pix_in_ready) rdy_seen = 1'b1;
      end
      pix_in_valid = 1'b0;
      total++;
      if (dcnt != 1 || first < 1 || first > 2) begin
        bad++; $display("FAIL empty_done[%0d]: pulses=%0d at=%0d want 1 pulse within 2", k, dcnt, first);
      end
      total++;
      if (rdy_seen) begin bad++; $display("FAIL empty_ready[%0d]: got 1 want 0", k); end
    end
  endtask

  task automatic test_reset_midrun();
    int n, as, mo, dc; bit ri, ok, ov_seen, dn_seen;
    n = 0; ov_seen = 1'b0; dn_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; cfg_num_channels = 7'd1; cfg_pix_per_channel = 16'd20; cfg_activation_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 30 && n < 8; c++) begin
      pix_in_valid = 1'b1; pix_in_data = 16'h3C00;
      #1;
      if (pix_in_ready) n++;
      @(negedge clk);
    end
    pix_in_valid = 1'b0;
    total++;
    if (n != 8) begin bad++; $display("FAIL rst_issue: got %0d want 8", n); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_state: out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) ov_seen = 1'b1;
      if (done) dn_seen = 1'b1;
    end
    out_ready = 1'b0;
    total++;
    if (ov_seen || dn_seen || err_overflow) begin
      bad++; $display("FAIL rst_stale: out_valid=%b done=%b overflow=%b want 0 0 0", ov_seen, dn_seen, err_overflow);
    end
    stream_layer(1, 10, 1'b0, 100, 0, 1'b0, -1, as, ri, mo, dc, ok);
    total++;
    if (!ok || dc != 1) begin bad++; $display("FAIL rst_next_layer: ok=%b done=%0d want 1 1", ok, dc); end
  endtask

  task automatic test_run_disturb();
    int as, mo, dc; bit ri, ok;
    write_const(0, 16'h4000, 16'h3C00);
    write_const(1, 16'h3800, 16'h4000);
    stream_layer(2, 10, 1'b1, 100, 0, 1'b0, 3, as, ri, mo, dc, ok);
    total++;
    if (!ok || obs_q.size() != 20) begin
      bad++; $display("FAIL dist_complete: ok=%b results=%0d want 20", ok, obs_q.size());
    end
    total++;
    if (dc != 1) begin bad++; $display("FAIL dist_done: got %0d want 1", dc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random_ready();
    test_empty_layer();
    test_reset_midrun();
    test_run_disturb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
